// File: rtl/vga_sync_output.sv
// 640x480@60 VGA raster generator: drives pixel coordinates upstream, takes the
// returning RRRGGGBB pixel back and emits 24-bit colour with syncs aligned to it.
module vga_sync_output #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  pixelRGB,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsyncN,
    output logic        vsyncN,
    output logic        blankN
);

    localparam int unsigned CW       = 11;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
    localparam int unsigned FLAG_W   = 3;
    localparam int unsigned DLY_W    = FLAG_W * PIPE_LAT;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_LIM = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_LIM = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_LO    = CW'(HS_START);
    localparam logic [CW-1:0] HS_HI    = CW'(HS_END);
    localparam logic [CW-1:0] VS_LO    = CW'(VS_START);
    localparam logic [CW-1:0] VS_HI    = CW'(VS_END);

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } flags_t;

    // run_q holds the counters at 0,0 for the first edge after reset release
    logic           run_q, run_d;
    logic [CW-1:0]  x_q, x_d;
    logic [CW-1:0]  y_q, y_d;
    logic           sof_q, sof_d;

    flags_t                  raw_c;
    flags_t [PIPE_LAT-1:0]   dly_q, dly_d;
    flags_t                  tail_c;

    logic [7:0]     red_q, red_d;
    logic [7:0]     green_q, green_d;
    logic [7:0]     blue_q, blue_d;
    logic           hs_n_q, hs_n_d;
    logic           vs_n_q, vs_n_d;
    logic           blank_n_q, blank_n_d;

    // Raster counters and start-of-frame pulse
    always_comb begin
        run_d = 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        if (run_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
        sof_d = (x_d == '0) && (y_d == '0);
    end

    // Raw flags for the coordinate currently presented; forced idle before the first frame
    always_comb begin
        raw_c        = '0;
        raw_c.active = run_q && (x_q < H_ACT_LIM) && (y_q < V_ACT_LIM);
        raw_c.hs     = run_q && (x_q >= HS_LO) && (x_q <= HS_HI);
        raw_c.vs     = run_q && (y_q >= VS_LO) && (y_q <= VS_HI);
    end

    // Flag delay line: the top stage drops out as the new flags shift in at stage 0
    always_comb begin
        dly_d  = DLY_W'({dly_q, raw_c});
        tail_c = dly_q[PIPE_LAT-1];
    end

    // Output stage: delayed flags and returning pixel registered together
    always_comb begin
        blank_n_d = tail_c.active;
        hs_n_d    = ~tail_c.hs;
        vs_n_d    = ~tail_c.vs;
        red_d     = '0;
        green_d   = '0;
        blue_d    = '0;
        if (tail_c.active) begin
            red_d   = {pixelRGB[7:5], pixelRGB[7:5], pixelRGB[7:6]};
            green_d = {pixelRGB[4:2], pixelRGB[4:2], pixelRGB[4:3]};
            blue_d  = {pixelRGB[1:0], pixelRGB[1:0], pixelRGB[1:0], pixelRGB[1:0]};
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            run_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            sof_q     <= 1'b0;
            dly_q     <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            hs_n_q    <= 1'b1;
            vs_n_q    <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sof_q     <= sof_d;
            dly_q     <= dly_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            hs_n_q    <= hs_n_d;
            vs_n_q    <= vs_n_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign pixelX       = x_q;
    assign pixelY       = y_q;
    assign startOfFrame = sof_q;
    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;
    assign hsyncN       = hs_n_q;
    assign vsyncN       = vs_n_q;
    assign blankN       = blank_n_q;

endmodule

// File: tb/tb_vga_sync_output.sv
// Scoreboard bench for vga_sync_output: full horizontal timing, shortened vertical
// timing (15 lines) so four frames with different pixel patterns fit the run.
module tb_vga_sync_output;

    localparam int HT     = 800;
    localparam int VT     = 15;
    localparam int LAT    = 3;              // PIPE_LAT + 1
    localparam int FRAME  = HT * VT;
    localparam int N_CYC  = FRAME * 4 + LAT;

    logic        clk;
    logic        resetN;
    logic [7:0]  pixelRGB;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame;
    logic [7:0]  red, green, blue;
    logic        hsyncN, vsyncN, blankN;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs_n;
        logic        vs_n;
        logic        blank_n;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sb_on    = 0;
    int   hs_pulses = 0;
    int   vs_pulses = 0;

    vga_sync_output #(
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut (
        .clk(clk), .resetN(resetN), .pixelRGB(pixelRGB),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .red(red), .green(green), .blue(blue),
        .hsyncN(hsyncN), .vsyncN(vsyncN), .blankN(blankN)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [23:0] expand(input logic [7:0] v);
        return {v[7:5], v[7:5], v[7:6], v[4:2], v[4:2], v[4:3],
                v[1:0], v[1:0], v[1:0], v[1:0]};
    endfunction

    // Expected colour for the pixel of coordinate index j (frame-based pattern)
    function automatic logic [23:0] exp_rgb(input int j);
        int f;
        logic [7:0] xv;
        f  = j / FRAME;
        xv = 8'((j % HT) & 255);
        case (f)
            0:       return 24'hFF_FF_FF;
            1:       return 24'hB6_49_55;
            2:       return 24'h00_00_00;
            default: return expand(xv);
        endcase
    endfunction

    function automatic exp_t model(input int k);
        exp_t e;
        int j, jx, jy;
        bit act;
        e.x   = 11'(k % HT);
        e.y   = 11'((k / HT) % VT);
        e.sof = (e.x == 0) && (e.y == 0);
        e.hs_n = 1'b1; e.vs_n = 1'b1; e.blank_n = 1'b0;
        e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
        if (k >= LAT) begin
            j  = k - LAT;
            jx = j % HT;
            jy = (j / HT) % VT;
            act = (jx < 640) && (jy < 8);
            e.blank_n = act;
            e.hs_n = !((jx >= 656) && (jx <= 751));
            e.vs_n = !((jy >= 10) && (jy <= 11));
            if (act) {e.r, e.g, e.b} = exp_rgb(j);
        end
        return e;
    endfunction

    // Driver: pushes the expectation for edge k and drives the pixel sampled at edge k
    initial begin
        logic [10:0] px_d1, px_d2, px_d3;
        int j;
        resetN   = 1'b0;
        pixelRGB = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk) resetN = 1'b1;
        repeat (300) @(posedge clk);
        #5 resetN = 1'b0;
        #1;
        chk("rst_x", int'(pixelX), 0);
        chk("rst_y", int'(pixelY), 0);
        chk("rst_sof", int'(startOfFrame), 0);
        chk("rst_rgb", int'({red, green, blue}), 0);
        chk("rst_hsync", int'(hsyncN), 1);
        chk("rst_vsync", int'(vsyncN), 1);
        chk("rst_blank", int'(blankN), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        px_d1 = '0; px_d2 = '0; px_d3 = '0;
        sb_q.push_back(model(0));
        pixelRGB = 8'h00;
        sb_on  = 1'b1;
        resetN = 1'b1;
        for (int k = 1; k < N_CYC; k++) begin
            @(posedge clk);
            #1;
            px_d3 = px_d2; px_d2 = px_d1; px_d1 = pixelX;
            sb_q.push_back(model(k));
            j = k - LAT;
            if (j < 0)                pixelRGB = 8'h00;
            else if (j < FRAME)       pixelRGB = 8'hFF;
            else if (j < 2 * FRAME)   pixelRGB = 8'b101_010_01;
            else if (j < 3 * FRAME)   pixelRGB = 8'h00;
            else                      pixelRGB = px_d3[7:0];
        end
        @(posedge clk);
        #5 sb_on = 1'b0;
        chk("sb_drained", sb_q.size(), 0);
        chk("hsync_pulses", hs_pulses, 60);
        chk("vsync_pulses", vs_pulses, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: compares every output cycle and measures sync pulse geometry
    initial begin
        exp_t e, got;
        int   k = 0;
        bit   prev_hs_n = 1'b1, prev_vs_n = 1'b1;
        int   hs_run = 0, vs_run = 0, hs_fall = -1, vs_fall = -1;
        forever begin
            @(posedge clk);
            #2;
            if (sb_on) begin
                got = {pixelX, pixelY, startOfFrame, red, green, blue, hsyncN, vsyncN, blankN};
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb_underflow at cycle %0d: no expectation queued", k);
                end else begin
                    e = sb_q.pop_front();
                    n_checks++;
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL cycle %0d: got x=%0d y=%0d sof=%b rgb=%h%h%h hs=%b vs=%b bl=%b, expected x=%0d y=%0d sof=%b rgb=%h%h%h hs=%b vs=%b bl=%b",
                                 k, got.x, got.y, got.sof, got.r, got.g, got.b, got.hs_n, got.vs_n, got.blank_n,
                                 e.x, e.y, e.sof, e.r, e.g, e.b, e.hs_n, e.vs_n, e.blank_n);
                    end
                end
                if (prev_hs_n && !hsyncN) begin
                    chk("hsync_start_x", int'(pixelX), 656 + LAT);
                    if (hs_fall >= 0) chk("line_period", k - hs_fall, HT);
                    hs_fall = k; hs_run = 0; hs_pulses++;
                end
                if (!prev_hs_n && hsyncN) chk("hsync_width", hs_run, 96);
                if (!hsyncN) hs_run++;
                if (prev_vs_n && !vsyncN) begin
                    chk("vsync_start", int'({pixelY, pixelX}), int'({11'd10, 11'(LAT)}));
                    if (vs_fall >= 0) chk("frame_period", k - vs_fall, FRAME);
                    vs_fall = k; vs_run = 0; vs_pulses++;
                end
                if (!prev_vs_n && vsyncN) chk("vsync_width", vs_run, 2 * HT);
                if (!vsyncN) vs_run++;
                prev_hs_n = hsyncN;
                prev_vs_n = vsyncN;
                k++;
            end
        end
    end

    initial begin
        #(40 * (N_CYC + 2000));
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
